// File: rtl/life_grid_engine.sv
// Parametrised B3/S23 Game-of-Life engine with row-serial load, status and LED row scan.
// Define LIFE_TORUS_EN for a toroidal grid; otherwise off-grid neighbours read as dead.
module life_grid_engine #(
    parameter int unsigned ROWS            = 8,
    parameter int unsigned COLS            = 8,
    parameter int unsigned GAME_DIVIDER    = 22,
    parameter int unsigned DISPLAY_DIVIDER = 14,
    parameter int unsigned GEN_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 step_req,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [COLS-1:0]      load_data,
    output logic                 load_ready,
    output logic [ROWS*COLS-1:0] cells,
    output logic [GEN_W-1:0]     generation,
    output logic                 extinct,
    output logic                 stable,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_drive
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned PW = $clog2(ROWS);
`ifdef LIFE_TORUS_EN
    localparam bit Torus = 1'b1;
`else
    localparam bit Torus = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StLoad} state_e;

    state_e                     state_q;
    logic                       load_ready_q;
    logic [PW-1:0]              row_ptr_q;
    logic [GAME_DIVIDER-1:0]    game_cnt_q;
    logic [DISPLAY_DIVIDER-1:0] disp_cnt_q;
    logic [N-1:0]               cells_q, cells_d, life_next;
    logic [GEN_W-1:0]           gen_q;
    logic                       stable_q;
    logic [ROWS-1:0]            row_sel_q;
    logic [ROWS-1:0]            row_we;
    logic                       game_tick, update, load_beat, first_beat, last_beat;

    assign game_tick  = (state_q == StRun) && (&game_cnt_q);
    // load_start pre-empts both the run tick and a single step
    assign update     = !load_start && (game_tick || ((state_q == StIdle) && step_req));
    assign load_beat  = load_ready_q && load_valid && !load_start;
    assign first_beat = load_beat && (row_ptr_q == '0);
    assign last_beat  = load_beat && (row_ptr_q == PW'(ROWS - 1));

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_we[r] = load_beat && (row_ptr_q == PW'(r));

        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned RN = (r == 0) ? ROWS - 1 : r - 1;
            localparam int unsigned RS = (r == ROWS - 1) ? 0 : r + 1;
            localparam int unsigned CW = (c == 0) ? COLS - 1 : c - 1;
            localparam int unsigned CE = (c == COLS - 1) ? 0 : c + 1;
            // Edge masks are constants, so the dead-border build drops the wrapped taps
            localparam bit HasN = Torus || (r != 0);
            localparam bit HasS = Torus || (r != ROWS - 1);
            localparam bit HasW = Torus || (c != 0);
            localparam bit HasE = Torus || (c != COLS - 1);

            logic [7:0] nbr;
            logic [3:0] cnt;

            assign nbr = {cells_q[RN*COLS+CW] & HasN & HasW,
                          cells_q[RN*COLS+c]  & HasN,
                          cells_q[RN*COLS+CE] & HasN & HasE,
                          cells_q[r*COLS+CW]  & HasW,
                          cells_q[r*COLS+CE]  & HasE,
                          cells_q[RS*COLS+CW] & HasS & HasW,
                          cells_q[RS*COLS+c]  & HasS,
                          cells_q[RS*COLS+CE] & HasS & HasE};

            assign cnt = {3'b000, nbr[0]} + {3'b000, nbr[1]} + {3'b000, nbr[2]} +
                         {3'b000, nbr[3]} + {3'b000, nbr[4]} + {3'b000, nbr[5]} +
                         {3'b000, nbr[6]} + {3'b000, nbr[7]};

            assign life_next[r*COLS+c] = (cnt == 4'd3) || (cells_q[r*COLS+c] && (cnt == 4'd2));
            assign cells_d[r*COLS+c]   = row_we[r] ? load_data[c] :
                                         update    ? life_next[r*COLS+c] : cells_q[r*COLS+c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            load_ready_q <= 1'b0;
            row_ptr_q    <= '0;
            game_cnt_q   <= '0;
            cells_q      <= '0;
            gen_q        <= '0;
            stable_q     <= 1'b0;
        end else begin
            cells_q <= cells_d;

            if (first_beat) begin
                gen_q    <= '0;
                stable_q <= 1'b0;
            end else if (update) begin
                stable_q <= (life_next == cells_q);
                if (!(&gen_q)) begin
                    gen_q <= gen_q + GEN_W'(1);
                end
            end

            // Only counts while staying in RUN; any exit clears it
            if ((state_q == StRun) && run && !load_start) begin
                game_cnt_q <= game_cnt_q + GAME_DIVIDER'(1);
            end else begin
                game_cnt_q <= '0;
            end

            if (load_start) begin
                state_q      <= StLoad;
                load_ready_q <= 1'b1;
                row_ptr_q    <= '0;
            end else begin
                case (state_q)
                    StIdle: if (run) state_q <= StRun;
                    StRun:  if (!run) state_q <= StIdle;
                    StLoad: begin
                        if (load_beat) begin
                            row_ptr_q <= row_ptr_q + PW'(1);
                            if (last_beat) begin
                                state_q      <= StIdle;
                                load_ready_q <= 1'b0;
                                row_ptr_q    <= '0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_cnt_q <= '0;
            row_sel_q  <= ROWS'(1);
        end else begin
            disp_cnt_q <= disp_cnt_q + DISPLAY_DIVIDER'(1);
            if (&disp_cnt_q) begin
                row_sel_q <= {row_sel_q[ROWS-2:0], row_sel_q[ROWS-1]};
            end
        end
    end

    always_comb begin
        col_drive = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel_q[r]) begin
                col_drive = col_drive | cells_q[r*COLS +: COLS];
            end
        end
    end

    assign cells      = cells_q;
    assign generation = gen_q;
    assign extinct    = ~|cells_q;
    assign stable     = stable_q;
    assign load_ready = load_ready_q;
    assign row_sel    = row_sel_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench for life_grid_engine on a 5x5 grid with short dividers.
module tb_life_grid_engine;

    localparam int R  = 5;
    localparam int C  = 5;
    localparam int GW = 16;

    typedef logic [R-1:0][C-1:0] grid_t;
    typedef struct {
        grid_t          cells;
        grid_t          mask;
        logic [GW-1:0]  gen;
        logic           stable;
        logic           chk_stable;
        logic           extinct;
    } exp_t;

    // Row r of a grid literal is the r-th field counted from the right
    localparam grid_t BLINK_V = {5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
    localparam grid_t BLINK_H = {5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000};
    localparam grid_t BLOCK   = {5'b00000, 5'b00000, 5'b00110, 5'b00110, 5'b00000};
    localparam grid_t SINGLE  = {5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000};
    localparam grid_t GLIDER  = {5'b11100, 5'b10000, 5'b01000, 5'b00000, 5'b00000};
    localparam grid_t PARTIAL = {5'b00000, 5'b00000, 5'b00110, 5'b11111, 5'b10001};
`ifdef LIFE_TORUS_EN
    localparam grid_t GL_END    = {5'b00001, 5'b00000, 5'b00000, 5'b10011, 5'b00010};
    localparam logic  GL_STABLE = 1'b0;
`else
    localparam grid_t GL_END    = {5'b11000, 5'b11000, 5'b00000, 5'b00000, 5'b00000};
    localparam logic  GL_STABLE = 1'b1;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           run = 1'b0;
    logic           step_req = 1'b0;
    logic           load_start = 1'b0;
    logic           load_valid = 1'b0;
    logic [C-1:0]   load_data = '0;
    logic           load_ready;
    logic [R*C-1:0] cells;
    logic [GW-1:0]  generation;
    logic           extinct;
    logic           stable;
    logic [R-1:0]   row_sel;
    logic [C-1:0]   col_drive;

    life_grid_engine #(
        .ROWS(R), .COLS(C), .GAME_DIVIDER(2), .DISPLAY_DIVIDER(2), .GEN_W(GW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .cells(cells), .generation(generation),
        .extinct(extinct), .stable(stable), .row_sel(row_sel), .col_drive(col_drive)
    );

    always #5 clk = ~clk;

    exp_t          sb[$];
    exp_t          mon_e;
    int            tests_run = 0;
    int            tests_failed = 0;
    int            nposed = 0;
    logic [GW-1:0] prev_gen = '0;

    // Posedges since reset release: the display divider's phase reference
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) nposed <= 0;
        else        nposed <= nposed + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // An update is visible as generation advancing by exactly one
    always @(negedge clk) begin
        if (rst_n && (generation == prev_gen + GW'(1))) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_update: got generation %0d, expected no update", generation);
            end else begin
                mon_e = sb.pop_front();
                chk("upd_gen", 32'(generation), 32'(mon_e.gen));
                chk("upd_cells", 32'(cells & mon_e.mask), 32'(mon_e.cells & mon_e.mask));
                chk("upd_extinct", 32'(extinct), 32'(mon_e.extinct));
                if (mon_e.chk_stable) chk("upd_stable", 32'(stable), 32'(mon_e.stable));
            end
        end
        prev_gen = generation;
    end

    task automatic push_exp(input grid_t g, input grid_t m, input int gen, input logic st,
                            input logic chk_st, input logic ext);
        exp_t e;
        e.cells = g; e.mask = m; e.gen = GW'(gen);
        e.stable = st; e.chk_stable = chk_st; e.extinct = ext;
        sb.push_back(e);
    endtask

    task automatic load_grid(input grid_t g);
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
        chk("load_ready_in_load", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        for (int r = 0; r < R; r++) begin
            load_data = g[r];
            @(posedge clk); #1;
        end
        load_valid = 1'b0;
        chk("load_ready_after", 32'(load_ready), 32'd0);
        chk("load_cells", 32'(cells), 32'(g));
    endtask

    task automatic do_step();
        @(posedge clk); #1 step_req = 1'b1;
        @(posedge clk); #1 step_req = 1'b0;
    endtask

    task automatic wait_gen(input int target, input int bound, output int at);
        bit hit = 1'b0;
        at = -1;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            if (generation == GW'(target)) begin
                hit = 1'b1;
                at  = nposed;
            end
        end
        if (!hit) chk("wait_gen_timeout", 32'(generation), 32'(target));
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        grid_t g;
        int    t1, t2, idx;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cells", 32'(cells), 32'd0);
        chk("reset_extinct", 32'(extinct), 32'd1);
        chk("reset_gen", 32'(generation), 32'd0);
        chk("reset_row_sel", 32'(row_sel), 32'b00001);
        chk("reset_load_ready", 32'(load_ready), 32'd0);
        chk("reset_stable", 32'(stable), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 2: blinker oscillates under single steps
        load_grid(BLINK_V);
        push_exp(BLINK_H, '1, 1, 1'b0, 1'b1, 1'b0);
        do_step();
        wait_drain(10);
        push_exp(BLINK_V, '1, 2, 1'b0, 1'b1, 1'b0);
        do_step();
        wait_drain(10);

        // 3: block is still life; then the row scan walks and wraps
        load_grid(BLOCK);
        push_exp(BLOCK, '1, 1, 1'b1, 1'b1, 1'b0);
        do_step();
        wait_drain(10);
        g = BLOCK;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            idx = (nposed / 4) % R;
            chk("scan_row_sel", 32'(row_sel), 32'(1) << idx);
            chk("scan_col_drive", 32'(col_drive), 32'(g[idx]));
        end

        // 4: auto-run, lone cell dies, 4-cycle period, step_req ignored
        load_grid(SINGLE);
        push_exp('0, '1, 1, 1'b0, 1'b1, 1'b1);
        push_exp('0, '1, 2, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1 run = 1'b1;
        wait_gen(1, 20, t1);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        wait_gen(2, 20, t2);
        run = 1'b0;
        chk("run_period", 32'(t2 - t1), 32'd4);
        wait_drain(10);
        repeat (6) @(negedge clk);
        chk("paused_gen", 32'(generation), 32'd2);

        // 5: load_start on a tick wins, partial load, then reset clears it
        load_grid(BLOCK);
        push_exp(BLOCK, '1, 1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1 run = 1'b1;
        wait_gen(1, 20, t1);
        repeat (3) @(posedge clk);
        #1 load_start = 1'b1; run = 1'b0;
        @(posedge clk); #1 load_start = 1'b0;
        chk("tick_vs_load_gen", 32'(generation), 32'd1);
        chk("tick_vs_load_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_data = 5'b10001;
        @(posedge clk); #1 load_data = 5'b11111;
        @(posedge clk); #1 load_valid = 1'b0;
        chk("partial_cells", 32'(cells), 32'(PARTIAL));
        chk("partial_gen", 32'(generation), 32'd0);
        chk("partial_stable", 32'(stable), 32'd0);
        chk("partial_ready", 32'(load_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midload_rst_cells", 32'(cells), 32'd0);
        chk("midload_rst_ready", 32'(load_ready), 32'd0);
        chk("midload_rst_extinct", 32'(extinct), 32'd1);
        chk("midload_rst_row_sel", 32'(row_sel), 32'b00001);
        @(posedge clk); #1 rst_n = 1'b1;

        // 6: glider from the bottom-right corner, 8 generations
        load_grid(GLIDER);
        for (int s = 1; s <= 8; s++) begin
            if (s == 8) push_exp(GL_END, '1, s, GL_STABLE, 1'b1, 1'b0);
            else        push_exp('0, '0, s, 1'b0, 1'b0, 1'b0);
            do_step();
            wait_drain(10);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
